// File: rtl/mc6502_int_conditioner.sv
// Conditions the 6502 IRQ/NMI pins into fetch-aligned requests for the interrupt logic.
// Latency: pin -> nmi_pend = SYNC_STAGES clk + 1 cen cycle; fetch strobe -> active-low request = 2 cen cycles.
// Backpressure: a latched request is held in SERVICE until the sequencer acks; cen=0 freezes all but the synchronizers.
//
// Ports:
//   clk, rst_x          system clock (rising edge), asynchronous active-low reset
//   cen                 clock enable for everything except the pin synchronizers
//   i_irq_x, i_nmi_x    asynchronous external interrupt pins, active-low
//   rf2ic_i             I flag from the register file (1 masks IRQ)
//   ex2ic_fetch         opcode-fetch boundary strobe from the sequencer
//   ex2ic_ack           sequencer has started the interrupt sequence
//   ic2il_irq_x/_nmi_x  conditioned active-low requests, asserted only in SERVICE
//   ic2ex_pending       high while a request is latched (ARMED or SERVICE)
//   ic2ex_vector        latched vector select: 01 NMI, 11 IRQ, 10 reset/none

module mc6502_int_conditioner #(
    // Synchronizer depth per pin; legal range 2..4.
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_x,
    input  logic       cen,
    input  logic       i_irq_x,
    input  logic       i_nmi_x,
    input  logic       rf2ic_i,
    input  logic       ex2ic_fetch,
    input  logic       ex2ic_ack,
    output logic       ic2il_irq_x,
    output logic       ic2il_nmi_x,
    output logic       ic2ex_pending,
    output logic [1:0] ic2ex_vector
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_SERVICE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] VEC_NMI  = 2'b01;
    localparam logic [1:0] VEC_IRQ  = 2'b11;
    localparam logic [1:0] VEC_NONE = 2'b10;

    // ------------------------------------------------------------------
    // Pin synchronizers. They run on every clk edge, independent of cen,
    // so pin metastability settles on real time rather than enabled time.
    // Reset to 1 (inactive) so releasing reset never fabricates an edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] irq_sync;
    logic [SYNC_STAGES-1:0] nmi_sync;
    logic                   irq_s;
    logic                   nmi_s;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            irq_sync <= '1;
            nmi_sync <= '1;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], i_irq_x};
            nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], i_nmi_x};
        end
    end

    assign irq_s = irq_sync[SYNC_STAGES-1];
    assign nmi_s = nmi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Enabled state
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nxt;
    logic [1:0] vector;
    logic [1:0] vector_nxt;
    logic       nmi_prev;
    logic       nmi_pend;
    logic       nmi_pend_nxt;

    logic       nmi_edge;
    logic       irq_req;
    logic       nmi_ack_clr;

    // NMI is edge-triggered: only a 1->0 transition seen across two
    // enabled cycles counts. A pin held low produces exactly one edge.
    assign nmi_edge = nmi_prev & ~nmi_s;

    // IRQ is level-sensitive and never latched: it must still be asserted
    // and unmasked whenever it is evaluated.
    assign irq_req  = ~irq_s & ~rf2ic_i;

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state    <= ST_IDLE;
            vector   <= VEC_NONE;
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else if (cen) begin
            state    <= state_nxt;
            vector   <= vector_nxt;
            nmi_prev <= nmi_s;
            nmi_pend <= nmi_pend_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        vector_nxt  = vector;
        nmi_ack_clr = 1'b0;

        case (state)
            ST_IDLE: begin
                // NMI wins over IRQ when both are present at the boundary.
                if (ex2ic_fetch && (nmi_pend || irq_req)) begin
                    state_nxt  = ST_ARMED;
                    vector_nxt = nmi_pend ? VEC_NMI : VEC_IRQ;
                end
            end
            ST_ARMED: begin
                // An IRQ that went away (pin released or masked) before
                // being presented is dropped; NMI always proceeds.
                if ((vector == VEC_IRQ) && !irq_req) begin
                    state_nxt  = ST_IDLE;
                    vector_nxt = VEC_NONE;
                end else begin
                    state_nxt  = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (ex2ic_ack) begin
                    state_nxt   = ST_HOLD;
                    nmi_ack_clr = (vector == VEC_NMI);
                end
            end
            ST_HOLD: begin
                // One-cycle guard so a fetch strobe arriving right after
                // the ack cannot immediately re-arm.
                state_nxt  = ST_IDLE;
                vector_nxt = VEC_NONE;
            end
            default: begin
                state_nxt  = ST_IDLE;
                vector_nxt = VEC_NONE;
            end
        endcase
    end

    // A fresh edge landing in the ack cycle must not be lost, so set
    // takes precedence over the ack clear.
    always_comb begin
        nmi_pend_nxt = nmi_pend;
        if (nmi_edge) begin
            nmi_pend_nxt = 1'b1;
        end else if (nmi_ack_clr) begin
            nmi_pend_nxt = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs decode directly from registered state, so they follow the
    // asynchronous reset immediately and hold while cen=0.
    // ------------------------------------------------------------------
    assign ic2ex_pending = (state == ST_ARMED) || (state == ST_SERVICE);
    assign ic2ex_vector  = vector;
    assign ic2il_nmi_x   = ~((state == ST_SERVICE) && (vector == VEC_NMI));
    assign ic2il_irq_x   = ~((state == ST_SERVICE) && (vector == VEC_IRQ));

endmodule
